// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - button sync/debounce and move/auto-repeat generator for the paddle
// Optional feature macro: PADDLE_ACCEL_EN (one move per frame once ACCEL_AFTER repeat moves are done)
module paddle_ctrl #(
  parameter int DB_PIX        = 250000,
  parameter int REPEAT_DELAY  = 15,
  parameter int REPEAT_PERIOD = 2,
  parameter int ACCEL_AFTER   = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixpulse,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic [3:0] btn,
  output logic       move,
  output logic [3:0] move_dir,
  output logic [3:0] btn_db
);

  localparam int             DBW         = $clog2(DB_PIX) + 1;
  localparam logic [DBW-1:0] DB_LAST     = DBW'(DB_PIX - 1);
  localparam logic [7:0]     DELAY_LAST  = 8'(REPEAT_DELAY - 1);
  localparam logic [7:0]     PERIOD_LAST = 8'(REPEAT_PERIOD - 1);

  if (DB_PIX < 1 || REPEAT_DELAY < 1 || REPEAT_DELAY > 255 || REPEAT_PERIOD < 1 ||
      REPEAT_PERIOD > 255 || ACCEL_AFTER < 0 || ACCEL_AFTER > 255) begin : g_bad_param
    $error("paddle_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t         state, state_nxt;
  logic [3:0]     sync_a, sync_b;
  logic [DBW-1:0] db_cnt [4];
  logic           move_pend, move_pend_nxt;
  logic [3:0]     move_dir_nxt;
  logic [7:0]     fcnt, fcnt_nxt;
  logic [7:0]     period_last;
  logic           frame_tick;
  logic           sel_ok;

  assign frame_tick = pixpulse && (hcount == 10'd0) && (vcount == 10'd0);
  assign sel_ok     = (btn_db != 4'b0000) && ((btn_db & (btn_db - 4'd1)) == 4'b0000);
  assign move       = move_pend & pixpulse;

`ifdef PADDLE_ACCEL_EN
  localparam logic [7:0] ACCEL_TH = 8'(ACCEL_AFTER);
  logic [7:0] rcnt, rcnt_nxt;
  assign period_last = (rcnt >= ACCEL_TH) ? 8'd0 : PERIOD_LAST;
`else
  assign period_last = PERIOD_LAST;
`endif

  // two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 4'b0000;
      sync_b <= 4'b0000;
    end else begin
      sync_a <= btn;
      sync_b <= sync_a;
    end
  end

  // per-button debounce: a change is accepted after DB_PIX consecutive differing pixel samples
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_db <= 4'b0000;
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else if (pixpulse) begin
      for (int i = 0; i < 4; i++) begin
        if (sync_b[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_db[i] <= sync_b[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // state register plus the move bookkeeping it owns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      move_pend <= 1'b0;
      move_dir  <= 4'b0000;
      fcnt      <= 8'd0;
`ifdef PADDLE_ACCEL_EN
      rcnt      <= 8'd0;
`endif
    end else begin
      state     <= state_nxt;
      move_pend <= move_pend_nxt;
      move_dir  <= move_dir_nxt;
      fcnt      <= fcnt_nxt;
`ifdef PADDLE_ACCEL_EN
      rcnt      <= rcnt_nxt;
`endif
    end
  end

  // next state: first move on press, delayed first repeat, then periodic repeats; a set pend wins over delivery
  always_comb begin
    state_nxt     = state;
    move_pend_nxt = move_pend & ~pixpulse;
    move_dir_nxt  = move_dir;
    fcnt_nxt      = fcnt;
`ifdef PADDLE_ACCEL_EN
    rcnt_nxt      = rcnt;
`endif
    case (state)
      IDLE: begin
`ifdef PADDLE_ACCEL_EN
        rcnt_nxt = 8'd0;
`endif
        if (sel_ok && !move_pend) begin
          move_dir_nxt  = btn_db;
          move_pend_nxt = 1'b1;
          fcnt_nxt      = 8'd0;
          state_nxt     = DELAY;
        end
      end
      DELAY: begin
        if (btn_db != move_dir) begin
          state_nxt = IDLE;
        end else if (frame_tick) begin
          if (fcnt >= DELAY_LAST) begin
            move_pend_nxt = 1'b1;
            fcnt_nxt      = 8'd0;
            state_nxt     = REPEAT;
          end else begin
            fcnt_nxt = fcnt + 8'd1;
          end
        end
      end
      REPEAT: begin
        if (btn_db != move_dir) begin
          state_nxt = IDLE;
        end else if (frame_tick) begin
          if (fcnt >= period_last) begin
            move_pend_nxt = 1'b1;
            fcnt_nxt      = 8'd0;
`ifdef PADDLE_ACCEL_EN
            if (rcnt != 8'hFF) rcnt_nxt = rcnt + 8'd1;
`endif
          end else begin
            fcnt_nxt = fcnt + 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - self-checking bench for paddle_ctrl against a behavioural move model
module tb_paddle_ctrl;

  localparam int DB_PIX        = 4;
  localparam int REPEAT_DELAY  = 3;
  localparam int REPEAT_PERIOD = 2;
  localparam int ACCEL_AFTER   = 2;
  localparam int HMAX          = 8;
  localparam int VMAX          = 4;
  localparam int FRAME         = HMAX * VMAX;
`ifdef PADDLE_ACCEL_EN
  localparam bit ACCEL = 1'b1;
`else
  localparam bit ACCEL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       pixpulse;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic [3:0] btn;
  logic       move;
  logic [3:0] move_dir;
  logic [3:0] btn_db;

  paddle_ctrl #(
    .DB_PIX(DB_PIX), .REPEAT_DELAY(REPEAT_DELAY),
    .REPEAT_PERIOD(REPEAT_PERIOD), .ACCEL_AFTER(ACCEL_AFTER)
  ) dut (
    .clk(clk), .rst(rst), .pixpulse(pixpulse), .hcount(hcount), .vcount(vcount),
    .btn(btn), .move(move), .move_dir(move_dir), .btn_db(btn_db)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int moves_seen = 0;
  int moves_model = 0;

  logic [3:0] m_db, m_dir, cur_btn;
  int         m_run [4];
  bit         m_pend, m_active, m_in_rst, rst_fired;
  int         m_ticks, m_moves;
  int         h, v;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_db = 4'b0000; m_dir = 4'b0000;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_pend = 1'b0; m_active = 1'b0; m_ticks = 0; m_moves = 0;
  endtask

  function automatic int need_gap();
    if (m_moves == 1) return REPEAT_DELAY;
    if (ACCEL && (m_moves - 2) >= ACCEL_AFTER) return 1;
    return REPEAT_PERIOD;
  endfunction

  // one pixel window of four clocks; b is driven from the second clock on
  task automatic pix(input logic [3:0] b, input bit arm_rst);
    @(posedge clk); #1;
    pixpulse = 1'b1; hcount = 10'(h); vcount = 10'(v);
    #1;
    check("move_on_pix", 16'(move), 16'(m_pend));
    check("move_dir", 16'(move_dir), 16'(m_dir));
    check("btn_db", 16'(btn_db), 16'(m_db));
    if (move === 1'b1) moves_seen++;
    if (!m_in_rst) begin
      if (m_pend) moves_model++;
      m_pend = 1'b0;
      if (m_active && h == 0 && v == 0) begin
        m_ticks++;
        if (m_ticks >= need_gap()) begin
          m_pend = 1'b1; m_ticks = 0; m_moves++;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (cur_btn[i] != m_db[i]) begin
          m_run[i]++;
          if (m_run[i] == DB_PIX) begin m_db[i] = cur_btn[i]; m_run[i] = 0; end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    @(posedge clk); #1;
    pixpulse = 1'b0; btn = b; cur_btn = b;
    if (m_in_rst) begin rst = 1'b0; m_in_rst = 1'b0; end
    if (m_active && m_db != m_dir) m_active = 1'b0;
    if (!m_active && $countones(m_db) == 1 && !m_pend) begin
      m_dir = m_db; m_pend = 1'b1; m_active = 1'b1; m_ticks = 0; m_moves = 1;
    end
    #1;
    check("move_off_pix1", 16'(move), 16'd0);
    check("btn_db_mid", 16'(btn_db), 16'(m_db));
    @(posedge clk); #1;
    if (arm_rst && m_pend && !m_in_rst) begin
      rst = 1'b1; model_reset(); m_in_rst = 1'b1; rst_fired = 1'b1;
    end
    #1;
    check("move_off_pix2", 16'(move), 16'd0);
    @(posedge clk); #1; #1;
    check("move_off_pix3", 16'(move), 16'd0);
    h++;
    if (h == HMAX) begin h = 0; v = (v + 1) % VMAX; end
  endtask

  logic [3:0] pats [8];
  int base;

  initial begin
    rst = 1'b1; pixpulse = 1'b0; hcount = 10'd0; vcount = 10'd0; btn = 4'b0000;
    cur_btn = 4'b0000; h = 0; v = 0; rst_fired = 1'b0; m_in_rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_move", 16'(move), 16'd0);
    check("reset_move_dir", 16'(move_dir), 16'd0);
    check("reset_btn_db", 16'(btn_db), 16'd0);
    rst = 1'b0;

    // short glitch on left never reaches btn_db
    repeat (3) pix(4'b0001, 1'b0);
    repeat (8) pix(4'b0000, 1'b0);
    check("glitch_moves", 16'(moves_seen), 16'd0);

    // hold left for 20 frames
    repeat (20 * FRAME) pix(4'b0001, 1'b0);
    repeat (16) pix(4'b0000, 1'b0);

    // up+left together gives nothing; dropping left leaves up
    base = moves_seen;
    repeat (3 * FRAME) pix(4'b1001, 1'b0);
    check("two_btn_moves", 16'(moves_seen - base), 16'd0);
    repeat (8 * FRAME) pix(4'b1000, 1'b0);
    check("up_dir", 16'(move_dir), 16'b1000);
    repeat (16) pix(4'b0000, 1'b0);

    // release inside the hold delay gives exactly one move
    base = moves_seen;
    repeat (DB_PIX + 4) pix(4'b0001, 1'b0);
    repeat (5 * FRAME) pix(4'b0000, 1'b0);
    check("delay_release_moves", 16'(moves_seen - base), 16'd1);

    // long hold on right: repeat spacing (with or without acceleration)
    repeat (15 * FRAME) pix(4'b0010, 1'b0);
    repeat (16) pix(4'b0000, 1'b0);

    // reset two clocks ahead of a pending first move
    rst_fired = 1'b0;
    for (int i = 0; i < 64 && !rst_fired; i++) pix(4'b0010, 1'b1);
    check("rst_reached_pending", 16'(rst_fired), 16'd1);
    base = moves_seen;
    pix(4'b0010, 1'b0);
    check("rst_no_move", 16'(moves_seen - base), 16'd0);
    check("rst_move_dir", 16'(move_dir), 16'd0);
    check("rst_btn_db", 16'(btn_db), 16'd0);
    repeat (3 * FRAME) pix(4'b0010, 1'b0);
    repeat (16) pix(4'b0000, 1'b0);

    // random button sequences
    pats[0] = 4'b0000; pats[1] = 4'b0001; pats[2] = 4'b0010; pats[3] = 4'b0100;
    pats[4] = 4'b1000; pats[5] = 4'b0011; pats[6] = 4'b1010; pats[7] = 4'b1110;
    for (int s = 0; s < 40; s++) begin
      logic [3:0] b;
      int len;
      b = pats[$urandom_range(0, 7)];
      len = $urandom_range(1, 120);
      repeat (len) pix(b, 1'b0);
    end
    repeat (16) pix(4'b0000, 1'b0);
    check("total_moves", 16'(moves_seen), 16'(moves_model));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
